// File: rtl/stopwatch_pkg.sv
// Shared types, limits and helpers for the stopwatch timekeeping stage.
package stopwatch_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } sw_state_e;

  // Largest value of a units digit and of a tens digit in a base-60 field
  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS6 = 4'd5;

  // Number of equal 1 kHz samples needed to accept a new button level
  localparam int DEB_SAMPLES_DEFAULT = 20;

  // Width of the debounce sample counter for the default sample count
  localparam int DEB_CNT_W = $clog2(DEB_SAMPLES_DEFAULT + 1);

  // MM:SS.cc as six BCD digits, most significant first (matches disp_bcd)
  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } bcd_time_t;

  localparam bcd_time_t BCD_TIME_ZERO = '0;

  // One BCD digit of a ripple counter: returns {carry_out, next_digit}.
  // A digit at its limit wraps to zero and passes the carry upward.
  function automatic logic [4:0] bcd_digit_step(input logic [3:0] digit,
                                                input logic [3:0] limit,
                                                input logic       carry_in);
    logic [4:0] result;
    result = {1'b0, digit};
    if (carry_in) begin
      if (digit >= limit) begin
        result = {1'b1, 4'd0};
      end else begin
        result = {1'b0, digit + 4'd1};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stopwatch_core_debounce.sv
// Button debouncer: 2-flop synchronizer, 1 kHz sample counter, press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int SAMPLES = DEB_SAMPLES_DEFAULT,
  parameter int CNT_W   = DEB_CNT_W
) (
  input  logic clk,
  input  logic clkcnt_reset,
  input  logic tick_1k,
  input  logic btn_raw,
  output logic press
);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] count_q;
  logic             press_q;
  logic             sample_differs;
  logic             count_done;

  // Bring the raw asynchronous button level into the clk domain
  always_ff @(posedge clk) begin
    if (!clkcnt_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign sample_differs = sync_q[1] ^ stable_q;
  assign count_done     = (count_q == CNT_W'(SAMPLES - 1));

  // Count consecutive differing samples; flip the stable level on the last one
  always_ff @(posedge clk) begin
    if (!clkcnt_reset) begin
      stable_q <= 1'b0;
      count_q  <= '0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (tick_1k) begin
        if (!sample_differs) begin
          count_q <= '0;
        end else if (count_done) begin
          stable_q <= ~stable_q;
          count_q  <= '0;
          press_q  <= ~stable_q;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: tick extraction, debounced controls, BCD counter,
// four-state control FSM and lap-frozen display selection.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT
) (
  input  logic        clk,
  input  logic        clkcnt_reset,
  input  logic        in_clk_1khz,
  input  logic        in_clk_100hz,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int CNT_W = $clog2(DEB_SAMPLES + 1);

  logic      clk1k_q;
  logic      clk100_q;
  logic      tick_1k;
  logic      tick_100;

  logic      press_ss;
  logic      press_lap;
  logic      press_clr;

  sw_state_e state_q;
  sw_state_e state_d;

  bcd_time_t cnt_q;
  bcd_time_t cnt_inc;
  bcd_time_t lap_q;
  logic      cnt_wrap;
  logic      ovf_q;

  logic      count_en;
  logic      do_clear;
  logic      do_capture;

  logic [4:0] step_cs_u;
  logic [4:0] step_cs_t;
  logic [4:0] step_sec_u;
  logic [4:0] step_sec_t;
  logic [4:0] step_min_u;
  logic [4:0] step_min_t;

  // Register the divider outputs once to find their rising edges
  always_ff @(posedge clk) begin
    if (!clkcnt_reset) begin
      clk1k_q  <= 1'b0;
      clk100_q <= 1'b0;
    end else begin
      clk1k_q  <= in_clk_1khz;
      clk100_q <= in_clk_100hz;
    end
  end

  assign tick_1k  = in_clk_1khz  & ~clk1k_q;
  assign tick_100 = in_clk_100hz & ~clk100_q;

  btn_debounce #(
    .SAMPLES (DEB_SAMPLES),
    .CNT_W   (CNT_W)
  ) u_deb_start_stop (
    .clk          (clk),
    .clkcnt_reset (clkcnt_reset),
    .tick_1k      (tick_1k),
    .btn_raw      (btn_start_stop),
    .press        (press_ss)
  );

  btn_debounce #(
    .SAMPLES (DEB_SAMPLES),
    .CNT_W   (CNT_W)
  ) u_deb_lap (
    .clk          (clk),
    .clkcnt_reset (clkcnt_reset),
    .tick_1k      (tick_1k),
    .btn_raw      (btn_lap),
    .press        (press_lap)
  );

  btn_debounce #(
    .SAMPLES (DEB_SAMPLES),
    .CNT_W   (CNT_W)
  ) u_deb_clear (
    .clk          (clk),
    .clkcnt_reset (clkcnt_reset),
    .tick_1k      (tick_1k),
    .btn_raw      (btn_clear),
    .press        (press_clr)
  );

  // Ripple carry through all six digits within one cycle
  assign step_cs_u  = bcd_digit_step(cnt_q.cs_u,  BCD_MAX_UNITS, 1'b1);
  assign step_cs_t  = bcd_digit_step(cnt_q.cs_t,  BCD_MAX_UNITS, step_cs_u[4]);
  assign step_sec_u = bcd_digit_step(cnt_q.sec_u, BCD_MAX_UNITS, step_cs_t[4]);
  assign step_sec_t = bcd_digit_step(cnt_q.sec_t, BCD_MAX_TENS6, step_sec_u[4]);
  assign step_min_u = bcd_digit_step(cnt_q.min_u, BCD_MAX_UNITS, step_sec_t[4]);
  assign step_min_t = bcd_digit_step(cnt_q.min_t, BCD_MAX_TENS6, step_min_u[4]);

  // Assemble the incremented time; a carry out of min_t means 59:59.99 wrapped
  always_comb begin
    cnt_inc       = BCD_TIME_ZERO;
    cnt_inc.cs_u  = step_cs_u[3:0];
    cnt_inc.cs_t  = step_cs_t[3:0];
    cnt_inc.sec_u = step_sec_u[3:0];
    cnt_inc.sec_t = step_sec_t[3:0];
    cnt_inc.min_u = step_min_u[3:0];
    cnt_inc.min_t = step_min_t[3:0];
    cnt_wrap      = step_min_t[4];
  end

  // Counting follows the current state, so a tick on the edge that leaves
  // RUN/LAP still counts and a tick on the edge that enters RUN does not
  assign count_en   = tick_100 && ((state_q == RUN) || (state_q == LAP));
  assign do_clear   = (state_q == PAUSE) && press_clr;
  assign do_capture = (state_q == RUN) && press_lap && !press_ss;

  // Next-state logic: start_stop beats lap, clear beats start_stop
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (press_ss) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (press_ss) begin
          state_d = PAUSE;
        end else if (press_lap) begin
          state_d = LAP;
        end
      end
      LAP: begin
        if (press_ss) begin
          state_d = PAUSE;
        end else if (press_lap) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (press_clr) begin
          state_d = IDLE;
        end else if (press_ss) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!clkcnt_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Live time counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!clkcnt_reset) begin
      cnt_q <= BCD_TIME_ZERO;
      ovf_q <= 1'b0;
    end else if (do_clear) begin
      cnt_q <= BCD_TIME_ZERO;
      ovf_q <= 1'b0;
    end else if (count_en) begin
      cnt_q <= cnt_inc;
      if (cnt_wrap) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Lap register takes the pre-increment time when entering LAP
  always_ff @(posedge clk) begin
    if (!clkcnt_reset) begin
      lap_q <= BCD_TIME_ZERO;
    end else if (do_capture) begin
      lap_q <= cnt_q;
    end
  end

  assign disp_bcd   = (state_q == LAP) ? lap_q : cnt_q;
  assign running    = (state_q == RUN) || (state_q == LAP);
  assign lap_active = (state_q == LAP);
  assign overflow   = ovf_q;

endmodule
